// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its PLL / downstream consumers.
// The sequencer side uses the master modport; observers and stimulus use slave.
`timescale 1ns/1ps
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_powerdown_n;
    logic       out_en;
    logic       sys_reset_n;
    logic       locked;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] loss_count;
    logic [2:0] state;

    modport master (
        input  pll_lock,
        input  restart,
        output pll_powerdown_n,
        output out_en,
        output sys_reset_n,
        output locked,
        output fail,
        output retry_count,
        output loss_count,
        output state
    );

    modport slave (
        output pll_lock,
        output restart,
        input  pll_powerdown_n,
        input  out_en,
        input  sys_reset_n,
        input  locked,
        input  fail,
        input  retry_count,
        input  loss_count,
        input  state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: power-down, wait for lock with timeout/retry, qualify lock
// stability, then release the PLL output domain; re-sequences on lock loss or restart.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int PD_CYCLES           = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pll_lock_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_PDOWN  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [23:0] PD_LAST      = 24'(PD_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

    logic        lock_sync_p0;
    logic        lock_s;
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        pd_n_q;
    logic        out_en_q;
    logic        sys_rst_n_q;
    logic        locked_q;
    logic        fail_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0 -> lock_s: two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync_p0 <= 1'b0;
            lock_s       <= 1'b0;
        end else begin
            lock_sync_p0 <= bus.pll_lock;
            lock_s       <= lock_sync_p0;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_PDOWN: begin
                if (cnt_q == PD_LAST) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_PDOWN;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) state_d = ST_WAIT;
                else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_PDOWN;
                    retry_d = 2'd0;
                    loss_d  = sat_inc8(loss_q);
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_PDOWN;
        endcase

        // Restart overrides the transition but leaves any loss just counted intact
        if (bus.restart) begin
            state_d = ST_PDOWN;
            retry_d = 2'd0;
        end

        if ((state_d != state_q) || bus.restart) begin
            cnt_d = 24'd0;
        end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Stage state register: outputs are registered from the next state so they
    // change on the same edge that enters the state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PDOWN;
            cnt_q       <= 24'd0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            pd_n_q      <= 1'b0;
            out_en_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pd_n_q      <= (state_d == ST_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
            out_en_q    <= (state_d == ST_RUN);
            sys_rst_n_q <= (state_d == ST_RUN);
            locked_q    <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign bus.pll_powerdown_n = pd_n_q;
    assign bus.out_en          = out_en_q;
    assign bus.sys_reset_n     = sys_rst_n_q;
    assign bus.locked          = locked_q;
    assign bus.fail            = fail_q;
    assign bus.retry_count     = retry_q;
    assign bus.loss_count      = loss_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: each queue entry holds the inputs for the
// next clock edge and the full output vector expected after that edge.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int S_PD = 0;
    localparam int S_WT = 1;
    localparam int S_ST = 2;
    localparam int S_RN = 3;
    localparam int S_FL = 4;

    typedef struct packed {
        logic        lock;
        logic        rs;
        logic [17:0] exp;
    } ent_t;

    logic clock;
    logic reset_n;
    logic reset_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    pll_lock_sequencer_if bus ();
    pll_lock_sequencer_if bus_b ();

    pll_lock_sequencer #(
        .PD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    pll_lock_sequencer #(
        .PD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(0)
    ) dut_b (
        .clock(clock), .reset_n(reset_b), .bus(bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] expv(input int st, input int rc, input int lc);
        logic pd, run, fl;
        pd  = (st >= S_WT) && (st <= S_RN);
        run = (st == S_RN);
        fl  = (st == S_FL);
        return {3'(st), pd, run, run, run, fl, 2'(rc), 8'(lc)};
    endfunction

    function automatic logic [17:0] observe();
        return {bus.state, bus.pll_powerdown_n, bus.out_en, bus.sys_reset_n,
                bus.locked, bus.fail, bus.retry_count, bus.loss_count};
    endfunction

    function automatic logic [17:0] observe_b();
        return {bus_b.state, bus_b.pll_powerdown_n, bus_b.out_en, bus_b.sys_reset_n,
                bus_b.locked, bus_b.fail, bus_b.retry_count, bus_b.loss_count};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic lk, input logic rs, input int st, input int rc,
                       input int lc, input int n);
        ent_t e;
        e.lock = lk;
        e.rs   = rs;
        e.exp  = expv(st, rc, lc);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Lock drop in RUN, 2-cycle sync + 1 to PDOWN, 4-cycle PDOWN, relock, back to RUN.
    task automatic add_loss_event(input int lprev, input int lnew);
        add(1'b0, 1'b0, S_RN, 0, lprev, 2);
        add(1'b0, 1'b0, S_PD, 0, lnew, 1);
        add(1'b1, 1'b0, S_PD, 0, lnew, 3);
        add(1'b1, 1'b0, S_WT, 0, lnew, 1);
        add(1'b1, 1'b0, S_ST, 0, lnew, 8);
        add(1'b1, 1'b0, S_RN, 0, lnew, 1);
    endtask

    task automatic test_reset();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        #1;
        got = observe();
        n_checks++;
        if (got !== expv(S_PD, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: observed %h, expected %h", got, expv(S_PD, 0, 0));
        end
        add(1'b1, 1'b0, S_PD, 0, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL reset_hold step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock_high();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b1, 1'b0, S_PD, 0, 0, 3);
        add(1'b1, 1'b0, S_WT, 0, 0, 1);
        add(1'b1, 1'b0, S_ST, 0, 0, 8);
        add(1'b1, 1'b0, S_RN, 0, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL lock_high step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_lock_loss_in_run();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add_loss_event(0, 1);
        add(1'b1, 1'b0, S_RN, 0, 1, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL lock_loss_in_run step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_stable_glitch();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b1, 1'b1, S_PD, 0, 1, 1);
        add(1'b1, 1'b0, S_PD, 0, 1, 3);
        add(1'b1, 1'b0, S_WT, 0, 1, 1);
        add(1'b1, 1'b0, S_ST, 0, 1, 4);
        add(1'b0, 1'b0, S_ST, 0, 1, 1);
        add(1'b1, 1'b0, S_ST, 0, 1, 1);
        add(1'b1, 1'b0, S_WT, 0, 1, 1);
        add(1'b1, 1'b0, S_ST, 0, 1, 8);
        add(1'b1, 1'b0, S_RN, 0, 1, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL stable_glitch step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_lock_low_fail();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b0, 1'b0, S_RN, 0, 1, 2);
        add(1'b0, 1'b0, S_PD, 0, 2, 4);
        add(1'b0, 1'b0, S_WT, 0, 2, 32);
        add(1'b0, 1'b0, S_PD, 1, 2, 4);
        add(1'b0, 1'b0, S_WT, 1, 2, 32);
        add(1'b0, 1'b0, S_PD, 2, 2, 4);
        add(1'b0, 1'b0, S_WT, 2, 2, 32);
        add(1'b0, 1'b0, S_FL, 2, 2, 20);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL lock_low_fail step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_restart_from_fail();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b1, 1'b1, S_PD, 0, 2, 1);
        add(1'b1, 1'b0, S_PD, 0, 2, 3);
        add(1'b1, 1'b0, S_WT, 0, 2, 1);
        add(1'b1, 1'b0, S_ST, 0, 2, 8);
        add(1'b1, 1'b0, S_RN, 0, 2, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL restart_from_fail step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_restart_in_pdown();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b1, 1'b1, S_PD, 0, 2, 1);
        add(1'b1, 1'b0, S_PD, 0, 2, 2);
        add(1'b1, 1'b1, S_PD, 0, 2, 1);
        add(1'b1, 1'b0, S_PD, 0, 2, 3);
        add(1'b1, 1'b0, S_WT, 0, 2, 1);
        add(1'b1, 1'b0, S_ST, 0, 2, 8);
        add(1'b1, 1'b0, S_RN, 0, 2, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL restart_in_pdown step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_restart_with_loss();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add(1'b0, 1'b0, S_RN, 0, 2, 2);
        add(1'b0, 1'b1, S_PD, 0, 3, 1);
        add(1'b1, 1'b0, S_PD, 0, 3, 3);
        add(1'b1, 1'b0, S_WT, 0, 3, 1);
        add(1'b1, 1'b0, S_ST, 0, 3, 8);
        add(1'b1, 1'b0, S_RN, 0, 3, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL restart_with_loss step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_zero_retries();
        logic [17:0] got;
        bus_b.pll_lock = 1'b0;
        bus_b.restart  = 1'b0;
        tick();
        reset_b = 1'b1;
        for (int i = 0; i < 35; i++) tick();
        n_checks++;
        if (bus_b.state !== 3'd1) begin
            n_fail++;
            $display("FAIL zero_retries_wait: observed state %0d, expected 1", bus_b.state);
        end
        tick();
        got = observe_b(); n_checks++;
        if (got !== expv(S_FL, 0, 0)) begin
            n_fail++;
            $display("FAIL zero_retries_fail: observed %h, expected %h", got, expv(S_FL, 0, 0));
        end
        for (int i = 0; i < 5; i++) tick();
        got = observe_b(); n_checks++;
        if (got !== expv(S_FL, 0, 0)) begin
            n_fail++;
            $display("FAIL zero_retries_hold: observed %h, expected %h", got, expv(S_FL, 0, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        add_loss_event(3, 4);
        add_loss_event(4, 5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL reset_mid_run_pre step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        got = observe(); n_checks++;
        if (got !== expv(S_PD, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_run_async: observed %h, expected %h", got, expv(S_PD, 0, 0));
        end
        add(1'b1, 1'b0, S_PD, 0, 0, 2);
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL reset_mid_run_hold step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
        reset_n = 1'b1;
        add(1'b1, 1'b0, S_PD, 0, 0, 3);
        add(1'b1, 1'b0, S_WT, 0, 0, 1);
        add(1'b1, 1'b0, S_ST, 0, 0, 8);
        add(1'b1, 1'b0, S_RN, 0, 0, 2);
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL reset_mid_run_relock step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    task automatic test_loss_saturation();
        ent_t e;
        logic [17:0] got;
        int k = 0;
        for (int i = 1; i <= 258; i++) begin
            add_loss_event((i - 1 > 255) ? 255 : i - 1, (i > 255) ? 255 : i);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pll_lock = e.lock; bus.restart = e.rs;
            tick();
            got = observe(); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL loss_saturation step %0d: observed %h, expected %h", k, got, e.exp);
            end
            k++;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        reset_b        = 1'b0;
        bus.pll_lock   = 1'b1;
        bus.restart    = 1'b0;
        bus_b.pll_lock = 1'b0;
        bus_b.restart  = 1'b0;
        test_reset();
        test_lock_high();
        test_lock_loss_in_run();
        test_stable_glitch();
        test_lock_low_fail();
        test_restart_from_fail();
        test_restart_in_pdown();
        test_restart_with_loss();
        test_zero_retries();
        test_reset_mid_run();
        test_loss_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 64: cycles pll_powerdown_n is held low per power-down phase.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles to wait for lock per attempt.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized lock-high cycles required before run.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: timed-out attempts retried before declaring failure; range 0..3.
REQ-005 SHALL have port clock, input, 1: free-running reference clock, same source as PLL reference input; sole clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_lock, input, 1: raw PLL lock indicator, asynchronous to clock.
REQ-008 SHALL have port restart, input, 1: single-cycle request to restart the full sequence.
REQ-009 SHALL have port pll_powerdown_n, output, 1: drives PLL power-down input, low = powered down.
REQ-010 SHALL have port out_en, output, 1: drives PLL OUT0 enable.
REQ-011 SHALL have port sys_reset_n, output, 1: active-low reset for logic clocked by the PLL output.
REQ-012 SHALL have port locked, output, 1: high only in RUN.
REQ-013 SHALL have port fail, output, 1: high only in FAIL.
REQ-014 SHALL have port retry_count, output, 2: timed-out attempts in the current sequence.
REQ-015 SHALL have port loss_count, output, 8: saturating count of lock losses seen in RUN.
REQ-016 SHALL have port state, output, 3: PDOWN=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.

Function
REQ-017 SHALL synchronize pll_lock through two flops into lock_s; lock_s lags pll_lock by 2 cycles.
REQ-018 SHALL drive all outputs from registers; an output SHALL change on the edge at which its state is entered.
REQ-019 SHALL use one 24-bit phase counter, cleared on every state entry; each parameter value SHALL be in 1..2^24-1.
REQ-020 PDOWN: SHALL hold pll_powerdown_n=0 and out_en=0 for exactly PD_CYCLES cycles, then enter WAIT.
REQ-021 WAIT: pll_powerdown_n=1; lock_s=1 -> STABLE; after LOCK_TIMEOUT_CYCLES cycles without lock_s -> retry handling.
REQ-022 Retry handling: if retry_count<MAX_RETRIES, SHALL increment retry_count and enter PDOWN; otherwise SHALL enter FAIL.
REQ-023 STABLE: SHALL enter RUN after LOCK_STABLE_CYCLES consecutive lock_s=1 cycles; any lock_s=0 -> WAIT with a fresh timeout window, retry_count unchanged.
REQ-024 RUN: SHALL hold out_en=1, locked=1 and sys_reset_n=1; all three SHALL be 0 in every other state.
REQ-025 RUN: one cycle of lock_s=0 SHALL enter PDOWN, clear retry_count, and increment loss_count, saturating at 255.
REQ-026 FAIL: SHALL hold pll_powerdown_n=0 and fail=1, and remain in FAIL until restart.
REQ-027 restart=1 in any state SHALL enter PDOWN with retry_count=0; loss_count SHALL be unchanged.
REQ-028 restart together with lock loss in RUN SHALL still increment loss_count once.
REQ-029 restart during PDOWN SHALL restart the PD_CYCLES count from zero.
REQ-030 With MAX_RETRIES=0, the first timeout SHALL enter FAIL.

Reset
REQ-031 On reset_n=0 the block SHALL immediately set state=PDOWN, pll_powerdown_n=0, out_en=0, sys_reset_n=0, locked=0, fail=0, retry_count=0, loss_count=0, counter=0 and both sync flops=0.
REQ-032 reset_n deassertion SHALL start PDOWN; reset_n asserted mid-operation SHALL act as REQ-031 regardless of state.

Verification (PD=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2)
REQ-033 Reset release with pll_lock tied high -> pll_powerdown_n low 4 cycles; STABLE 8 cycles; locked, out_en and sys_reset_n rise together; retry_count=0.
REQ-034 pll_lock tied low -> three 32-cycle WAIT windows; retry_count steps 0->1->2; then fail=1, pll_powerdown_n=0, state=4, held indefinitely.
REQ-035 Single-cycle pll_lock drop at STABLE count 5 -> state returns to WAIT; RUN only after 8 further consecutive lock cycles.
REQ-036 pll_lock falls in RUN -> locked and sys_reset_n fall 3 edges later (2 sync + 1); loss_count=1; 4-cycle PDOWN; relock to RUN.
REQ-037 From FAIL, pulse restart -> fail=0, retry_count=0, PDOWN 4 cycles; with lock high, normal sequence to RUN.
REQ-038 reset_n low mid-RUN with loss_count=5 -> all outputs at reset values without a clock edge; loss_count=0.
